// File: rtl/adder_traffic_master.sv
// rtl/adder_traffic_master.sv - operand generator and in-order response checker for the valid/ready adder
module adder_traffic_master #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             mode,
   input  logic [15:0]      seed,
   input  logic [CNT_W-1:0] num_txn,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [7:0]       op_a,
   output logic [7:0]       op_b,
   input  logic             res_valid,
   output logic             res_ready,
   input  logic [8:0]       res_data,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_flag,
   output logic [CNT_W-1:0] first_err_idx
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FIFO_FULL = DEPTH[AW:0];
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nxt;

   logic             mode_r;
   logic [CNT_W-1:0] num_r, issued, received;
   logic [15:0]      gen, gen_nxt;
   logic [8:0]       fifo_mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      fifo_cnt;
   logic             fifo_full, fifo_empty;
   logic             op_hs, res_hs, pop, mismatch, err_evt, start_acc, done_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : CNT_W'(v + 1);
   endfunction

   assign fifo_full  = (fifo_cnt == FIFO_FULL);
   assign fifo_empty = (fifo_cnt == '0);
   assign op_valid   = (state == RUN) && (issued < num_r) && !fifo_full;
   assign res_ready  = (state != IDLE);
   assign busy       = (state != IDLE);
   assign op_a       = gen[15:8];
   assign op_b       = gen[7:0];
   assign op_hs      = op_valid & op_ready;
   assign res_hs     = res_valid & res_ready;
   assign pop        = res_hs & !fifo_empty;
   assign mismatch   = pop && (res_data != fifo_mem[rd_ptr]);
   // A response with nothing outstanding counts as an error; it never consumes a same-cycle push.
   assign err_evt    = mismatch || (res_hs && fifo_empty);
   assign start_acc  = (state == IDLE) && start;
   assign gen_nxt    = mode_r ? 16'(gen + 16'd1)
                              : {gen[14:0], gen[15] ^ gen[13] ^ gen[12] ^ gen[10]};

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (num_txn == '0) done_nxt = 1'b1;
               else               state_nxt = RUN;
            end
         end
         RUN: begin
            if (op_hs && (CNT_W'(issued + 1) == num_r)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (pop && (CNT_W'(received + 1) == num_r)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (op_hs) fifo_mem[wr_ptr] <= {1'b0, op_a} + {1'b0, op_b};
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= IDLE;
         done          <= 1'b0;
         mode_r        <= 1'b0;
         num_r         <= '0;
         gen           <= '0;
         issued        <= '0;
         received      <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_cnt      <= '0;
         pass_cnt      <= '0;
         err_cnt       <= '0;
         err_flag      <= 1'b0;
         first_err_idx <= '0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
         if (start_acc) begin
            mode_r        <= mode;
            num_r         <= num_txn;
            gen           <= (!mode && seed == 16'h0000) ? 16'h0001 : seed;
            issued        <= '0;
            received      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            pass_cnt      <= '0;
            err_cnt       <= '0;
            err_flag      <= 1'b0;
            first_err_idx <= '0;
         end else begin
            if (op_hs) begin
               gen    <= gen_nxt;
               issued <= sat_inc(issued);
               wr_ptr <= AW'(wr_ptr + 1);
            end
            if (pop) begin
               rd_ptr   <= AW'(rd_ptr + 1);
               received <= sat_inc(received);
               if (!mismatch) pass_cnt <= sat_inc(pass_cnt);
            end
            if (err_evt) begin
               err_cnt  <= sat_inc(err_cnt);
               err_flag <= 1'b1;
               if (!err_flag) first_err_idx <= received;
            end
            if (op_hs && !pop)      fifo_cnt <= (AW+1)'(fifo_cnt + 1);
            else if (!op_hs && pop) fifo_cnt <= (AW+1)'(fifo_cnt - 1);
         end
      end
   end
endmodule

// File: tb/tb_adder_traffic_master.sv
// tb/tb_adder_traffic_master.sv - directed bench for adder_traffic_master acting as the adder
module tb_adder_traffic_master;
   logic        clk = 1'b0;
   logic        rstn, start, mode;
   logic [15:0] seed, num_txn;
   logic        op_valid, op_ready;
   logic [7:0]  op_a, op_b;
   logic        res_valid, res_ready;
   logic [8:0]  res_data;
   logic        busy, done, err_flag;
   logic [15:0] pass_cnt, err_cnt, first_err_idx;

   int checks = 0;
   int failures = 0;

   logic [15:0] ops[$];
   logic [8:0]  rq[$];
   int          done_seen, hs_in_hold, stab_err, busy_at_done, done_cyc, last_res_cyc;
   logic        ov_end_hold;

   always #5 clk = ~clk;

   adder_traffic_master #(.DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rstn(rstn), .start(start), .mode(mode), .seed(seed), .num_txn(num_txn),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy), .done(done), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
      .err_flag(err_flag), .first_err_idx(first_err_idx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_op_valid"}, 32'(op_valid), 32'd0);
      check({tag, "_res_ready"}, 32'(res_ready), 32'd0);
      check({tag, "_ops"}, 32'({op_a, op_b}), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass_cnt), 32'd0);
      check({tag, "_err"}, 32'(err_cnt), 32'd0);
      check({tag, "_flag"}, 32'(err_flag), 32'd0);
      check({tag, "_idx"}, 32'(first_err_idx), 32'd0);
   endtask

   // Acts as the adder: accepts operands, returns sums in order, with optional stalls and faults.
   task automatic run(input string tag, input logic m, input logic [15:0] sd, input logic [15:0] n,
                      input int rdy_lo_from, input int rdy_lo_to, input int resp_hold,
                      input int xor_idx, input int spur_cyc, input int restart_cyc);
      int   cyc, resp_idx;
      logic op_hs, res_hs, holding;
      logic [15:0] held;
      ops.delete(); rq.delete();
      done_seen = 0; hs_in_hold = 0; stab_err = 0; busy_at_done = 0;
      done_cyc = -1; last_res_cyc = -2; ov_end_hold = 1'b0;
      @(negedge clk);
      mode = m; seed = sd; num_txn = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0; resp_idx = 0; holding = 1'b0; held = '0;
      while (cyc < 400) begin
         if (done) begin
            done_seen = 1; busy_at_done = 32'(busy); done_cyc = cyc;
            break;
         end
         op_ready = !(cyc >= rdy_lo_from && cyc < rdy_lo_to);
         if (cyc == spur_cyc && rq.size() == 0) begin
            res_valid = 1'b1; res_data = 9'h055;
         end else if (cyc >= resp_hold && rq.size() > 0) begin
            res_valid = 1'b1;
            res_data  = rq[0] ^ ((resp_idx == xor_idx) ? 9'h001 : 9'h000);
         end else begin
            res_valid = 1'b0; res_data = '0;
         end
         if (holding && (!op_valid || {op_a, op_b} !== held)) stab_err++;
         op_hs  = op_valid && op_ready;
         res_hs = res_valid && res_ready;
         if (res_hs && rq.size() > 0) begin
            void'(rq.pop_front());
            resp_idx++;
            last_res_cyc = cyc;
         end
         if (op_hs) begin
            ops.push_back({op_a, op_b});
            rq.push_back({1'b0, op_a} + {1'b0, op_b});
            if (cyc < resp_hold) hs_in_hold++;
         end
         if (cyc == resp_hold - 1) ov_end_hold = op_valid;
         holding = op_valid && !op_ready;
         held    = {op_a, op_b};
         if (cyc == restart_cyc) begin
            start = 1'b1; num_txn = 16'd2; seed = 16'h7777; mode = ~m;
         end else start = 1'b0;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0; op_ready = 1'b0; res_valid = 1'b0;
      check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
      if (done_seen == 1) begin
         check({tag, "_done_latency"}, 32'(done_cyc), 32'(last_res_cyc + 1));
         check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
      end
      @(negedge clk);
      check({tag, "_done_single"}, 32'(done), 32'd0);
   endtask

   initial begin
      rstn = 1'b0; start = 1'b1; mode = 1'b1; seed = 16'h0005; num_txn = 16'd3;
      op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rstn = 1'b1; start = 1'b0;
      @(negedge clk);
      check("rst_start_ignored", 32'(busy), 32'd0);
      check("rst_no_valid", 32'(op_valid), 32'd0);

      run("cnt", 1'b1, 16'h0102, 16'd3, 0, 0, 0, -1, -1, -1);
      check("cnt_n", 32'(ops.size()), 32'd3);
      if (ops.size() == 3) begin
         check("cnt_op0", 32'(ops[0]), 32'h0102);
         check("cnt_op1", 32'(ops[1]), 32'h0103);
         check("cnt_op2", 32'(ops[2]), 32'h0104);
      end
      check("cnt_pass", 32'(pass_cnt), 32'd3);
      check("cnt_err", 32'(err_cnt), 32'd0);
      repeat (3) @(negedge clk);
      check("cnt_hold_idle", 32'(pass_cnt), 32'd3);

      run("carry", 1'b1, 16'hFFFF, 16'd2, 0, 0, 0, -1, -1, -1);
      if (ops.size() == 2) begin
         check("carry_op0", 32'(ops[0]), 32'hFFFF);
         check("carry_op1", 32'(ops[1]), 32'h0000);
      end
      check("carry_pass", 32'(pass_cnt), 32'd2);
      check("carry_err", 32'(err_cnt), 32'd0);

      run("fault", 1'b0, 16'hACE1, 16'd8, 0, 0, 0, 2, -1, -1);
      if (ops.size() == 8) begin
         check("lfsr_op0", 32'(ops[0]), 32'hACE1);
         check("lfsr_op1", 32'(ops[1]), 32'h59C3);
         check("lfsr_op2", 32'(ops[2]), 32'hB387);
      end
      check("fault_err", 32'(err_cnt), 32'd1);
      check("fault_idx", 32'(first_err_idx), 32'd2);
      check("fault_flag", 32'(err_flag), 32'd1);
      check("fault_pass", 32'(pass_cnt), 32'd7);

      run("bp", 1'b1, 16'h0010, 16'd8, 0, 0, 12, -1, -1, 5);
      check("bp_outstanding", 32'(hs_in_hold), 32'd4);
      check("bp_valid_low", 32'(ov_end_hold), 32'd0);
      check("bp_n", 32'(ops.size()), 32'd8);
      if (ops.size() == 8) check("bp_op7", 32'(ops[7]), 32'h0017);
      check("bp_pass", 32'(pass_cnt), 32'd8);
      check("bp_err", 32'(err_cnt), 32'd0);

      run("stall", 1'b1, 16'h2000, 16'd6, 2, 7, 0, -1, -1, -1);
      check("stall_stable", 32'(stab_err), 32'd0);
      if (ops.size() == 6) check("stall_op2", 32'(ops[2]), 32'h2002);
      check("stall_pass", 32'(pass_cnt), 32'd6);

      run("spur", 1'b1, 16'h0300, 16'd2, 0, 4, 0, -1, 1, -1);
      check("spur_err", 32'(err_cnt), 32'd1);
      check("spur_flag", 32'(err_flag), 32'd1);
      check("spur_idx", 32'(first_err_idx), 32'd0);
      check("spur_pass", 32'(pass_cnt), 32'd2);

      @(negedge clk);
      mode = 1'b1; seed = 16'h1234; num_txn = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_err_cleared", 32'(err_cnt), 32'd0);
      @(negedge clk);
      check("zero_done_single", 32'(done), 32'd0);
      check("zero_busy_after", 32'(busy), 32'd0);

      mode = 1'b1; seed = 16'h4000; num_txn = 16'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op_ready = 1'b1; res_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy_before", 32'(busy), 32'd1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1; op_ready = 1'b0;
      check_reset("abort");
      done_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/adder_traffic_master.md
# adder_traffic_master

Initiator and checker for the 8-bit valid/ready adder. It generates operand pairs, drives them into the adder's input handshake, and accepts 9-bit sums from the adder's output handshake. Each sum is compared against a locally computed expected value held in a small in-order FIFO. The block sits beside the adder in self-test and bring-up builds, and reports pass/error counts to a status/CSR layer.

## Interface
Parameters:
- DEPTH, 4 — expected-sum FIFO entries (power of 2, ≥2); bounds outstanding transactions.
- CNT_W, 16 — width of transaction count, index and pass/error counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a run; ignored unless idle.
- mode  in  1  sampled on start: 0 = LFSR operands, 1 = counter sweep.
- seed  in  16  sampled on start: LFSR seed or sweep start value.
- num_txn  in  CNT_W  sampled on start: transactions to issue.
- op_valid  out  1  operand pair valid (to adder valid_i).
- op_ready  in  1  adder ready (from adder ready_i).
- op_a  out  8  first operand (to adder data1_i).
- op_b  out  8  second operand (to adder data2_i).
- res_valid  in  1  result valid (from adder valid_o).
- res_ready  out  1  result accept (to adder ready_o).
- res_data  in  9  sum (from adder data_out_o).
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pass_cnt  out  CNT_W  matching responses this run.
- err_cnt  out  CNT_W  mismatching plus unexpected responses this run.
- err_flag  out  1  sticky: any error this run.
- first_err_idx  out  CNT_W  response index of the first error.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on start.
  - RUN→DRAIN on the last op handshake.
  - DRAIN→IDLE when the received count equals num_txn.
  - If num_txn = 0: IDLE→IDLE on start, done pulsed, counters cleared.
- Start acceptance: captures mode, seed and num_txn. Clears issued/received counts, pass_cnt, err_cnt, err_flag, first_err_idx and the FIFO.
- Operand generator: 16-bit register gen.
  - Load: gen = seed on start. In mode 0, seed 0 is replaced by 16'h0001.
  - op_a = gen[15:8], op_b = gen[7:0].
  - Advance only on an op handshake (op_valid & op_ready).
  - Mode 0: shift left, bit0 = gen[15]^gen[13]^gen[12]^gen[10].
  - Mode 1: gen+1, wrapping 0xFFFF→0x0000.
- op_valid = (state==RUN) & (issued < num_txn) & !fifo_full. This is a combinational function of registers only; it does not depend on op_ready.
- Op handshake pushes the 9-bit zero-extended sum op_a+op_b into the FIFO and increments issued.
- res_ready = 1 in RUN and DRAIN, 0 in IDLE.
- Result handshake (res_valid & res_ready):
  - FIFO non-empty: pop the head and compare. Equal → pass_cnt+1. Unequal → err_cnt+1. Received count +1.
  - FIFO empty (unexpected response): err_cnt+1 and err_flag set. The received count is unchanged. A push in the same cycle does not satisfy the pop.
  - First error of a run: first_err_idx = received count before increment; err_flag set.
- Simultaneous push and pop: occupancy unchanged, both take effect.
- Counters saturate at all-ones.
- Status outputs hold their values in IDLE until the next accepted start.
- busy = (state != IDLE).

## Timing
- Reset values:
  - op_valid=0, res_ready=0, op_a=op_b=0 (gen=0).
  - busy=0, done=0, pass_cnt=err_cnt=0, err_flag=0, first_err_idx=0.
  - FIFO empty, state IDLE.
- Reset mid-run aborts immediately: all state returns to reset values, no done pulse.
- Start latency: op_valid can first assert in the cycle after start is sampled.
- Operand stability: while op_valid & !op_ready, op_valid, op_a and op_b hold stable.
- Throughput: one op handshake per cycle when op_ready=1 and the FIFO is not full. At most DEPTH transactions are outstanding.
- done is registered: it pulses in the cycle after the final result handshake, and busy falls in that same cycle.
- Compare happens in the handshake cycle; counters update on the next edge.

## Test plan
- Reset: hold rstn=0 3 cycles → every output at its reset value; start asserted during reset is ignored.
- Counter mode, correct zero-wait responder: mode=1, seed=0x0102, num_txn=3 → ops (01,02),(01,03),(01,04); pass_cnt=3, err_cnt=0; one done pulse.
- Carry boundary: mode=1, seed=0xFFFF, num_txn=2 → ops (FF,FF) expect 0x1FE, then (00,00) expect 0x000; pass_cnt=2.
- Fault injection: mode=0, seed=0xACE1, num_txn=8, responder XORs bit0 on response 2 → err_cnt=1, first_err_idx=2, err_flag=1, pass_cnt=7.
- Backpressure: DEPTH=4, res_valid held 0 → exactly 4 op handshakes, then op_valid=0. op_ready low 5 cycles mid-run → op_a/op_b constant throughout.
- Edge cases:
  - num_txn=0 → done in the cycle after start, busy never 1.
  - start while busy → ignored.
  - Spurious res_valid with an empty FIFO → err_cnt=1.
  - rstn=0 mid-run → no done pulse, reset values.
